mem_access_ctrl: RTL and testbench

- Initiator-side controller that drives the byte-addressable data memory: address, write data, read enable and write enable.
- Accepts load/store requests from the pipeline over a valid/ready handshake and converts byte/half/word accesses into aligned 32-bit memory transactions.
- Sub-word stores are done as read-modify-write.
- Sign/zero-extended load data and an error flag are returned over a valid/ready response channel.

---
 rtl/mem_access_ctrl.sv | 114 +++++++++++
 tb/tb_mem_access_ctrl.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: load/store request controller for a byte-addressable 32-bit data memory.
// Sub-word stores use read-modify-write; loads return sign/zero-extended data.
module mem_access_ctrl #(
    parameter int awidth = 32,
    parameter int dwidth = 32,
    parameter logic [awidth-1:0] base_addr = 32'h01000000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              req_we_i,
    input  logic [awidth-1:0] req_addr_i,
    input  logic [dwidth-1:0] req_wdata_i,
    input  logic [1:0]        req_size_i,
    input  logic              req_unsigned_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [dwidth-1:0] resp_rdata_o,
    output logic              resp_err_o,
    output logic [awidth-1:0] mem_addr_o,
    output logic [dwidth-1:0] mem_data_o,
    output logic              mem_read_en_o,
    output logic              mem_write_en_o,
    input  logic [dwidth-1:0] mem_data_i
);
    typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_t;

    state_t            state_q, state_d;
    logic              we_q, we_d, uns_q, uns_d, err_q, err_d;
    logic [awidth-1:0] addr_q, addr_d;
    logic [dwidth-1:0] wdata_q, wdata_d, word_q, word_d, rdata_q, rdata_d;
    logic [1:0]        size_q, size_d;
    logic              req_err;
    logic [4:0]        sh;
    logic [31:0]       shifted, ld_data, mask, ins, st_data;

    assign req_err = (req_size_i == 2'b11) || (req_size_i == 2'b01 && req_addr_i[0])
                  || (req_size_i == 2'b10 && req_addr_i[1:0] != 2'b00);
    assign sh      = {addr_q[1:0], 3'b000};
    assign shifted = mem_data_i >> sh;
    assign ld_data = size_q == 2'b00 ? {{24{shifted[7] & ~uns_q}}, shifted[7:0]}
                   : size_q == 2'b01 ? {{16{shifted[15] & ~uns_q}}, shifted[15:0]}
                   : mem_data_i;
    // Sub-word stores splice the new lane(s) into the word fetched during READ.
    assign mask    = (size_q == 2'b00 ? 32'h0000_00FF : 32'h0000_FFFF) << sh;
    assign ins     = (size_q == 2'b00 ? {24'h0, wdata_q[7:0]} : {16'h0, wdata_q[15:0]}) << sh;
    assign st_data = size_q == 2'b10 ? wdata_q : (word_q & ~mask) | ins;

    assign req_ready_o    = state_q == IDLE;
    assign resp_valid_o   = state_q == RESP;
    assign resp_rdata_o   = rdata_q;
    assign resp_err_o     = err_q;
    assign mem_read_en_o  = state_q == READ;
    assign mem_write_en_o = state_q == WRITE;
    assign mem_addr_o     = (state_q == READ || state_q == WRITE) ? {addr_q[awidth-1:2], 2'b00} : base_addr;
    assign mem_data_o     = state_q == WRITE ? st_data : '0;

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        uns_d   = uns_q;
        err_d   = err_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        word_d  = word_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: if (req_valid_i) begin
                we_d    = req_we_i;
                uns_d   = req_unsigned_i;
                addr_d  = req_addr_i;
                wdata_d = req_wdata_i;
                size_d  = req_size_i;
                err_d   = req_err;
                rdata_d = '0;
                state_d = req_err ? RESP : (!req_we_i || req_size_i != 2'b10) ? READ : WRITE;
            end
            READ: begin
                word_d  = mem_data_i;
                rdata_d = we_q ? '0 : ld_data;
                state_d = we_q ? WRITE : RESP;
            end
            WRITE: state_d = RESP;
            RESP: state_d = resp_ready_i ? IDLE : RESP;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            size_q  <= '0;
            word_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            err_q   <= err_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            word_q  <= word_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl against a small word-array memory model.
module tb_mem_access_ctrl;
    logic        clk = 0, rst = 0;
    logic        req_valid_i = 0, req_we_i = 0, req_unsigned_i = 0, resp_ready_i = 1;
    logic [31:0] req_addr_i = 0, req_wdata_i = 0;
    logic [1:0]  req_size_i = 0;
    logic        req_ready_o, resp_valid_o, resp_err_o, mem_read_en_o, mem_write_en_o;
    logic [31:0] resp_rdata_o, mem_addr_o, mem_data_o, mem_data_i;
    logic [31:0] mem [16] = '{1: 32'h8899AABB, default: 32'h0};

    always #5 clk = ~clk;

    mem_access_ctrl dut (
        .clk(clk), .rst(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_we_i(req_we_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
        .resp_rdata_o(resp_rdata_o), .resp_err_o(resp_err_o), .mem_addr_o(mem_addr_o),
        .mem_data_o(mem_data_o), .mem_read_en_o(mem_read_en_o), .mem_write_en_o(mem_write_en_o),
        .mem_data_i(mem_data_i)
    );

    assign mem_data_i = mem[mem_addr_o[5:2]];
    always @(posedge clk) if (mem_write_en_o) mem[mem_addr_o[5:2]] <= mem_data_o;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          lat, rd, wr;
        logic [31:0] mdata;
        int          acc;
    } exp_t;
    exp_t sb[$];
    int n_chk = 0, n_fail = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endfunction

    int rd_cnt = 0, wr_cnt = 0, lat_meas = 0;
    logic [31:0] wseen = 0;
    logic both = 0, seen = 0;

    always @(negedge clk) begin
        if (!rst) begin
            rd_cnt = 0; wr_cnt = 0; both = 0; seen = 0;
        end else begin
            if (mem_read_en_o) rd_cnt++;
            if (mem_write_en_o) begin wr_cnt++; wseen = mem_data_o; end
            if (mem_read_en_o && mem_write_en_o) both = 1;
            if (resp_valid_o && !seen) begin
                seen = 1;
                lat_meas = cyc - (sb.size() > 0 ? sb[0].acc : 0);
            end
            if (resp_valid_o && resp_ready_i) begin
                if (sb.size() == 0) begin
                    n_chk++; n_fail++;
                    $display("FAIL unexpected_resp: got rdata %h err %b expected none", resp_rdata_o, resp_err_o);
                end else begin
                    automatic exp_t e = sb.pop_front();
                    chk("resp_rdata", resp_rdata_o, e.rdata);
                    chk("resp_err", {31'b0, resp_err_o}, {31'b0, e.err});
                    chk("latency", lat_meas, e.lat);
                    chk("read_cycles", rd_cnt, e.rd);
                    chk("write_cycles", wr_cnt, e.wr);
                    if (e.wr > 0) chk("mem_wdata", wseen, e.mdata);
                    chk("rd_wr_overlap", {31'b0, both}, 32'h0);
                end
                rd_cnt = 0; wr_cnt = 0; both = 0; seen = 0;
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        while (sb.size() != 0 && t < 20) begin @(posedge clk); #2; t++; end
        if (sb.size() != 0) begin
            n_chk++; n_fail++;
            $display("FAIL resp_timeout: got no response expected %0d pending", sb.size());
            sb.delete();
        end
    endtask

    task automatic issue(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [1:0] size, input logic uns, input logic [31:0] exp_rdata,
                         input logic exp_err, input int lat, input int rd, input int wr,
                         input logic [31:0] mdata, input bit wait_done = 1);
        exp_t e;
        int t = 0;
        while (!req_ready_o && t < 20) begin @(posedge clk); #2; t++; end
        chk("req_ready_before_issue", {31'b0, req_ready_o}, 32'h1);
        req_we_i = we; req_addr_i = addr; req_wdata_i = wdata; req_size_i = size;
        req_unsigned_i = uns; req_valid_i = 1;
        @(posedge clk); #1;
        e.rdata = exp_rdata; e.err = exp_err; e.lat = lat; e.rd = rd; e.wr = wr;
        e.mdata = mdata; e.acc = cyc - 1;
        sb.push_back(e);
        #1 req_valid_i = 0;
        if (wait_done) wait_idle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        #3;
        chk("rst_resp_valid", {31'b0, resp_valid_o}, 32'h0);
        chk("rst_resp_rdata", resp_rdata_o, 32'h0);
        chk("rst_resp_err", {31'b0, resp_err_o}, 32'h0);
        chk("rst_enables", {30'b0, mem_read_en_o, mem_write_en_o}, 32'h0);
        chk("rst_mem_addr", mem_addr_o, 32'h01000000);
        chk("rst_mem_data", mem_data_o, 32'h0);
        @(posedge clk); @(posedge clk); #2 rst = 1;
        #1 chk("rst_req_ready", {31'b0, req_ready_o}, 32'h1);
        @(posedge clk); #2;
        // loads
        issue(0, 32'h01000004, 0, 2'b10, 0, 32'h8899AABB, 0, 2, 1, 0, 0);
        issue(0, 32'h01000007, 0, 2'b00, 0, 32'hFFFFFF88, 0, 2, 1, 0, 0);
        issue(0, 32'h01000007, 0, 2'b00, 1, 32'h00000088, 0, 2, 1, 0, 0);
        issue(0, 32'h01000006, 0, 2'b01, 0, 32'hFFFF8899, 0, 2, 1, 0, 0);
        issue(0, 32'h01000004, 0, 2'b01, 1, 32'h0000AABB, 0, 2, 1, 0, 0);
        // reset in the middle of a WRITE must not commit
        req_we_i = 1; req_addr_i = 32'h01000004; req_wdata_i = 32'h11111111;
        req_size_i = 2'b10; req_valid_i = 1;
        @(posedge clk); #1;
        chk("pre_reset_write_en", {31'b0, mem_write_en_o}, 32'h1);
        rst = 0; req_valid_i = 0;
        #1 chk("reset_write_en_drop", {31'b0, mem_write_en_o}, 32'h0);
        @(posedge clk); @(posedge clk); #2 rst = 1;
        #1 chk("post_reset_req_ready", {31'b0, req_ready_o}, 32'h1);
        chk("post_reset_resp_valid", {31'b0, resp_valid_o}, 32'h0);
        chk("reset_no_commit", mem[1], 32'h8899AABB);
        @(posedge clk); #2;
        // stores
        issue(1, 32'h01000005, 32'h1234565A, 2'b00, 0, 32'h0, 0, 3, 1, 1, 32'h88995ABB);
        issue(0, 32'h01000004, 0, 2'b10, 0, 32'h88995ABB, 0, 2, 1, 0, 0);
        issue(1, 32'h01000008, 32'hDEADBEEF, 2'b10, 0, 32'h0, 0, 2, 0, 1, 32'hDEADBEEF);
        issue(1, 32'h0100000A, 32'h0000CAFE, 2'b01, 0, 32'h0, 0, 3, 1, 1, 32'hCAFEBEEF);
        issue(0, 32'h0100000B, 0, 2'b00, 0, 32'hFFFFFFCA, 0, 2, 1, 0, 0);
        // errors
        issue(0, 32'h01000005, 0, 2'b01, 0, 32'h0, 1, 1, 0, 0, 0);
        issue(1, 32'h01000004, 32'h77777777, 2'b11, 0, 32'h0, 1, 1, 0, 0, 0);
        issue(0, 32'h01000002, 0, 2'b10, 1, 32'h0, 1, 1, 0, 0, 0);
        chk("err_no_write", mem[1], 32'h88995ABB);
        // back-pressure: response held, new requests ignored
        resp_ready_i = 0;
        issue(0, 32'h01000008, 0, 2'b10, 0, 32'hCAFEBEEF, 0, 2, 1, 0, 0, 0);
        for (int t = 0; t < 10 && !resp_valid_o; t++) begin @(posedge clk); #2; end
        for (int i = 0; i < 3; i++) begin
            req_we_i = 1; req_addr_i = 32'h0100000C; req_wdata_i = 32'h55555555;
            req_size_i = 2'b10; req_valid_i = 1;
            chk("hold_resp_valid", {31'b0, resp_valid_o}, 32'h1);
            chk("hold_resp_rdata", resp_rdata_o, 32'hCAFEBEEF);
            chk("hold_req_ready", {31'b0, req_ready_o}, 32'h0);
            @(posedge clk); #2;
        end
        req_valid_i = 0; resp_ready_i = 1;
        wait_idle();
        chk("after_hs_req_ready", {31'b0, req_ready_o}, 32'h1);
        chk("ignored_req_no_write", mem[3], 32'h0);
        repeat (3) @(posedge clk);
        chk("no_stray_resp", {31'b0, resp_valid_o}, 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
